// File: rtl/apb3_drive_master.sv
// APB3 initiator for the dual H-bridge slave. One accepted drive command is
// expanded into an ordered list of register writes (speed-zero before any
// direction reversal, then both directions, then both speeds) and issued as
// standard SETUP/ACCESS transfers. Completion, slave error and PREADY timeout
// are reported with a one-cycle done pulse.
module apb3_drive_master #(
  parameter logic [31:0] BASE_ADDR      = 32'h4005_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_m1_dir,
  input  logic        cmd_m2_dir,
  input  logic [7:0]  cmd_m1_speed,
  input  logic [7:0]  cmd_m2_speed,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        timeout
);

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WAIT_LIM = WW'(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Write-list slots, issued lowest index first:
  //   0: M1 speed zero   1: M2 speed zero   2: M1 dir   3: M2 dir
  //   4: M1 speed        5: M2 speed
  function automatic logic [2:0] first_entry(input logic [5:0] mask);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (mask[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [31:0] entry_addr(input logic [2:0] idx);
    logic [31:0] off;
    case (idx)
      3'd0, 3'd4: off = 32'h8;
      3'd1, 3'd5: off = 32'hC;
      3'd2:       off = 32'h0;
      default:    off = 32'h4;
    endcase
    return BASE_ADDR + off;
  endfunction

  function automatic logic [31:0] entry_data(input logic [2:0] idx, input logic d1,
                                             input logic d2, input logic [7:0] s1,
                                             input logic [7:0] s2);
    logic [31:0] v;
    case (idx)
      3'd2:    v = {31'd0, d1};
      3'd3:    v = {31'd0, d2};
      3'd4:    v = {24'd0, s1};
      3'd5:    v = {24'd0, s2};
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [5:0]    pend_q, pend_d;
  logic          dir1_q, dir1_d, dir2_q, dir2_d;
  logic [7:0]    spd1_q, spd1_d, spd2_q, spd2_d;
  logic          m1_dir_q, m1_dir_d, m2_dir_q, m2_dir_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [31:0]   paddr_q, paddr_d, pwdata_q, pwdata_d;
  logic          ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic          err_q, err_d, timeout_q, timeout_d;

  logic [2:0]    cur_idx, nxt_idx, acc_idx;
  logic [5:0]    nxt_mask, acc_mask;
  logic [WW-1:0] wait_inc;
  logic          finish;

  // Next-state logic: accept, sequence through the write list, terminate.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    dir1_d    = dir1_q;
    dir2_d    = dir2_q;
    spd1_d    = spd1_q;
    spd2_d    = spd2_q;
    m1_dir_d  = m1_dir_q;
    m2_dir_d  = m2_dir_q;
    wait_d    = wait_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    timeout_d = timeout_q;
    finish    = 1'b0;

    cur_idx  = first_entry(pend_q);
    nxt_mask = pend_q & ~(6'd1 << cur_idx);
    nxt_idx  = first_entry(nxt_mask);
    acc_mask = {4'b1111, cmd_m2_dir != m2_dir_q, cmd_m1_dir != m1_dir_q};
    acc_idx  = first_entry(acc_mask);
    wait_inc = wait_q + WW'(1);

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (cmd_valid) begin
          dir1_d    = cmd_m1_dir;
          dir2_d    = cmd_m2_dir;
          spd1_d    = cmd_m1_speed;
          spd2_d    = cmd_m2_speed;
          pend_d    = acc_mask;
          paddr_d   = entry_addr(acc_idx);
          pwdata_d  = entry_data(acc_idx, cmd_m1_dir, cmd_m2_dir, cmd_m1_speed, cmd_m2_speed);
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = 1'b1;
          ready_d   = 1'b0;
          busy_d    = 1'b1;
          err_d     = 1'b0;
          timeout_d = 1'b0;
          wait_d    = '0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        wait_d    = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          if (PSLVERR) begin
            err_d  = 1'b1;
            finish = 1'b1;
          end else begin
            // Shadow tracks the slave only once its dir write has landed.
            if (cur_idx == 3'd2) m1_dir_d = dir1_q;
            if (cur_idx == 3'd3) m2_dir_d = dir2_q;
            if (nxt_mask == 6'd0) begin
              finish = 1'b1;
            end else begin
              pend_d    = nxt_mask;
              paddr_d   = entry_addr(nxt_idx);
              pwdata_d  = entry_data(nxt_idx, dir1_q, dir2_q, spd1_q, spd2_q);
              penable_d = 1'b0;
              state_d   = S_SETUP;
            end
          end
        end else if (wait_inc == WAIT_LIM) begin
          timeout_d = 1'b1;
          finish    = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
      pwrite_d  = 1'b0;
      pend_d    = 6'd0;
      ready_d   = 1'b1;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      state_d   = S_DONE;
    end
  end

  // State and registered outputs; reset drops the bus at once and forgets the command.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      pend_q    <= 6'd0;
      dir1_q    <= 1'b0;
      dir2_q    <= 1'b0;
      spd1_q    <= 8'd0;
      spd2_q    <= 8'd0;
      m1_dir_q  <= 1'b0;
      m2_dir_q  <= 1'b0;
      wait_q    <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= 32'd0;
      pwdata_q  <= 32'd0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      dir1_q    <= dir1_d;
      dir2_q    <= dir2_d;
      spd1_q    <= spd1_d;
      spd2_q    <= spd2_d;
      m1_dir_q  <= m1_dir_d;
      m2_dir_q  <= m2_dir_d;
      wait_q    <= wait_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign timeout   = timeout_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb3_drive_master.sv
// Bench for apb3_drive_master: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a write-list model.
module tb_apb3_drive_master;

  localparam logic [31:0] BASE = 32'h4005_0000;
  localparam int TO = 16;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_m1_dir = 1'b0;
  logic        cmd_m2_dir = 1'b0;
  logic [7:0]  cmd_m1_speed = 8'd0;
  logic [7:0]  cmd_m2_speed = 8'd0;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;
  logic        busy, done, err, timeout;

  apb3_drive_master #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_m1_dir(cmd_m1_dir), .cmd_m2_dir(cmd_m2_dir),
    .cmd_m1_speed(cmd_m1_speed), .cmd_m2_speed(cmd_m2_speed),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR),
    .busy(busy), .done(done), .err(err), .timeout(timeout)
  );

  initial forever #5 PCLK = ~PCLK;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  initial forever begin
    @(posedge PCLK);
    cyc = cyc + 1;
  end

  // slave responder configuration
  int          resp_waits = 0;
  bit          resp_stuck = 1'b0;
  bit          resp_rand = 1'b0;
  bit          err_en = 1'b0;
  logic [31:0] err_addr = 32'd0;

  // observations of the DUT, used by the directed literal checks
  int          done_cnt = 0;
  int          acc_cyc = 0;
  int          last_lat = 0;
  logic        last_err = 1'b0;
  logic        last_to = 1'b0;
  logic [31:0] log_a[$];
  logic [31:0] log_d[$];

  // behavioural model: pending write list plus per-transfer progress
  bit          m_active = 1'b0, m_first = 1'b0, m_done_now = 1'b0;
  bit          m_err = 1'b0, m_to = 1'b0, m_sh1 = 1'b0, m_sh2 = 1'b0;
  int          m_waits = 0;
  logic [31:0] m_qa[$];
  logic [31:0] m_qd[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
  endtask

  // Slave: PREADY after resp_waits low ACCESS cycles, or random, or never.
  initial begin
    int acc_n;
    bit rdy;
    acc_n = 0;
    forever begin
      @(posedge PCLK);
      #1;
      if (PSEL && PENABLE) begin
        if (resp_stuck)     rdy = 1'b0;
        else if (resp_rand) rdy = ($urandom_range(0, 2) == 0);
        else                rdy = (acc_n >= resp_waits);
        acc_n++;
      end else begin
        acc_n = 0;
        rdy = 1'($urandom_range(0, 1));
      end
      PREADY = rdy;
      if (rdy && PSEL && PENABLE)
        PSLVERR = (err_en && PADDR == err_addr) || (resp_rand && $urandom_range(0, 19) == 0);
      else
        PSLVERR = 1'($urandom_range(0, 1));
    end
  end

  // Compare process: every cycle, DUT outputs against the model, then advance the model.
  initial begin
    bit nd;
    logic [31:0] a, d;
    forever begin
      @(negedge PCLK);
      if (PRESET) begin
        chk("rst_PSEL", 32'(PSEL), 32'd0);
        chk("rst_PENABLE", 32'(PENABLE), 32'd0);
        chk("rst_PWRITE", 32'(PWRITE), 32'd0);
        chk("rst_PADDR", PADDR, 32'd0);
        chk("rst_PWDATA", PWDATA, 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        m_active = 0; m_first = 0; m_done_now = 0; m_err = 0; m_to = 0;
        m_sh1 = 0; m_sh2 = 0; m_waits = 0;
        m_qa.delete(); m_qd.delete();
      end else begin
        chk("PSEL", 32'(PSEL), 32'(m_active));
        chk("PENABLE", 32'(PENABLE), 32'(m_active && !m_first));
        chk("PWRITE", 32'(PWRITE), 32'(m_active));
        chk("cmd_ready", 32'(cmd_ready), 32'(!m_active));
        chk("busy", 32'(busy), 32'(m_active));
        chk("done", 32'(done), 32'(m_done_now));
        chk("err", 32'(err), 32'(m_err));
        chk("timeout", 32'(timeout), 32'(m_to));
        if (m_active) begin
          chk("PADDR", PADDR, m_qa[0]);
          chk("PWDATA", PWDATA, m_qd[0]);
        end

        if (done) begin
          done_cnt++;
          last_lat = cyc - acc_cyc;
          last_err = err;
          last_to  = timeout;
        end
        if (cmd_valid && cmd_ready) begin
          log_a.delete(); log_d.delete();
          acc_cyc = cyc;
        end
        if (PSEL && PENABLE && PREADY) begin
          log_a.push_back(PADDR);
          log_d.push_back(PWDATA);
        end

        nd = 1'b0;
        if (m_active) begin
          if (m_first) begin
            m_first = 1'b0;
            m_waits = 0;
          end else if (PREADY) begin
            if (PSLVERR) begin
              m_err = 1'b1;
              m_qa.delete(); m_qd.delete();
              m_active = 1'b0;
              nd = 1'b1;
            end else begin
              a = m_qa.pop_front();
              d = m_qd.pop_front();
              if (a == BASE)       m_sh1 = d[0];
              if (a == BASE + 32'h4) m_sh2 = d[0];
              if (m_qa.size() == 0) begin
                m_active = 1'b0;
                nd = 1'b1;
              end else begin
                m_first = 1'b1;
              end
            end
          end else begin
            m_waits++;
            if (m_waits == TO) begin
              m_to = 1'b1;
              m_qa.delete(); m_qd.delete();
              m_active = 1'b0;
              nd = 1'b1;
            end
          end
        end else if (cmd_valid) begin
          m_err = 1'b0;
          m_to  = 1'b0;
          if (cmd_m1_dir != m_sh1) begin m_qa.push_back(BASE + 32'h8); m_qd.push_back(32'd0); end
          if (cmd_m2_dir != m_sh2) begin m_qa.push_back(BASE + 32'hC); m_qd.push_back(32'd0); end
          m_qa.push_back(BASE);          m_qd.push_back(32'(cmd_m1_dir));
          m_qa.push_back(BASE + 32'h4);  m_qd.push_back(32'(cmd_m2_dir));
          m_qa.push_back(BASE + 32'h8);  m_qd.push_back(32'(cmd_m1_speed));
          m_qa.push_back(BASE + 32'hC);  m_qd.push_back(32'(cmd_m2_speed));
          m_active = 1'b1;
          m_first  = 1'b1;
        end
        m_done_now = nd;
      end
    end
  end

  task automatic send_cmd(input bit d1, input logic [7:0] s1, input bit d2, input logic [7:0] s2);
    int n;
    n = 0;
    @(posedge PCLK); #1;
    while (!cmd_ready && n < 300) begin
      @(posedge PCLK); #1;
      n++;
    end
    if (!cmd_ready) begin
      fail_now("cmd_ready_wait");
      return;
    end
    cmd_valid = 1'b1;
    cmd_m1_dir = d1; cmd_m1_speed = s1;
    cmd_m2_dir = d2; cmd_m2_speed = s2;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    cmd_m1_dir = 1'($urandom_range(0, 1)); cmd_m1_speed = 8'($urandom);
    cmd_m2_dir = 1'($urandom_range(0, 1)); cmd_m2_speed = 8'($urandom);
  endtask

  task automatic wait_done(input int prev);
    int n;
    n = 0;
    while (done_cnt == prev && n < 400) begin
      @(negedge PCLK); #1;
      n++;
    end
    if (done_cnt == prev) fail_now("done_wait");
  endtask

  task automatic run_cmd(input bit d1, input logic [7:0] s1, input bit d2, input logic [7:0] s2);
    int prev;
    prev = done_cnt;
    send_cmd(d1, s1, d2, s2);
    wait_done(prev);
  endtask

  task automatic check_seq(input string nm, input int n, input logic [31:0] ea[6],
                           input logic [31:0] ed[6], input int lat, input bit e, input bit t);
    chk({nm, "_count"}, 32'(log_a.size()), 32'(n));
    for (int i = 0; i < n && i < log_a.size(); i++) begin
      chk($sformatf("%s_addr%0d", nm, i), log_a[i], ea[i]);
      chk($sformatf("%s_data%0d", nm, i), log_d[i], ed[i]);
    end
    chk({nm, "_latency"}, 32'(last_lat), 32'(lat));
    chk({nm, "_err"}, 32'(last_err), 32'(e));
    chk({nm, "_timeout"}, 32'(last_to), 32'(t));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ea[6];
    logic [31:0] ed[6];
    int prev, n, k;

    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;

    // forward start: no zeroing writes
    run_cmd(1'b0, 8'd200, 1'b0, 8'd50);
    ea = '{BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC, 32'd0, 32'd0};
    ed = '{32'd0, 32'd0, 32'd200, 32'd50, 32'd0, 32'd0};
    check_seq("fwd", 4, ea, ed, 9, 1'b0, 1'b0);

    // M1 reversal: zero M1 speed first
    run_cmd(1'b1, 8'd100, 1'b0, 8'd50);
    ea = '{BASE + 32'h8, BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC, 32'd0};
    ed = '{32'd0, 32'd1, 32'd0, 32'd100, 32'd50, 32'd0};
    check_seq("rev1", 5, ea, ed, 11, 1'b0, 1'b0);

    // three wait states per ACCESS, directions unchanged
    resp_waits = 3;
    run_cmd(1'b1, 8'd100, 1'b0, 8'd50);
    ea = '{BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC, 32'd0, 32'd0};
    ed = '{32'd1, 32'd0, 32'd100, 32'd50, 32'd0, 32'd0};
    check_seq("wait3", 4, ea, ed, 21, 1'b0, 1'b0);
    resp_waits = 0;

    // slave error on the M1 dir write aborts the rest
    err_en = 1'b1; err_addr = BASE;
    run_cmd(1'b0, 8'd10, 1'b0, 8'd20);
    ea = '{BASE + 32'h8, BASE, 32'd0, 32'd0, 32'd0, 32'd0};
    ed = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    check_seq("slverr", 2, ea, ed, 5, 1'b1, 1'b0);
    err_en = 1'b0;

    // shadow still reverse, so M1 is zeroed again
    run_cmd(1'b0, 8'd30, 1'b0, 8'd40);
    ea = '{BASE + 32'h8, BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC, 32'd0};
    ed = '{32'd0, 32'd0, 32'd0, 32'd30, 32'd40, 32'd0};
    check_seq("rezero", 5, ea, ed, 11, 1'b0, 1'b0);

    // PREADY stuck low
    resp_stuck = 1'b1;
    run_cmd(1'b0, 8'd1, 1'b0, 8'd2);
    check_seq("stuck", 0, ea, ed, 18, 1'b0, 1'b1);
    resp_stuck = 1'b0;

    run_cmd(1'b0, 8'd3, 1'b0, 8'd4);
    ea = '{BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC, 32'd0, 32'd0};
    ed = '{32'd0, 32'd0, 32'd3, 32'd4, 32'd0, 32'd0};
    check_seq("after_to", 4, ea, ed, 9, 1'b0, 1'b0);

    // both reversed: six writes
    run_cmd(1'b1, 8'd9, 1'b1, 8'd9);
    ea = '{BASE + 32'h8, BASE + 32'hC, BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC};
    ed = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd9, 32'd9};
    check_seq("rev_both", 6, ea, ed, 13, 1'b0, 1'b0);

    // reset during the third ACCESS
    prev = done_cnt;
    send_cmd(1'b0, 8'd5, 1'b0, 8'd6);
    n = 0; k = 0;
    while (k < 3 && n < 100) begin
      @(negedge PCLK); #1;
      if (PSEL && PENABLE) k++;
      n++;
    end
    if (k < 3) fail_now("third_access_wait");
    #1 PRESET = 1'b1;
    #1;
    chk("midrst_PSEL", 32'(PSEL), 32'd0);
    chk("midrst_PENABLE", 32'(PENABLE), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge PCLK);
    @(posedge PCLK); #1 PRESET = 1'b0;
    repeat (4) @(negedge PCLK);
    #1 chk("midrst_no_done", 32'(done_cnt), 32'(prev));

    run_cmd(1'b0, 8'd7, 1'b0, 8'd8);
    ea = '{BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC, 32'd0, 32'd0};
    ed = '{32'd0, 32'd0, 32'd7, 32'd8, 32'd0, 32'd0};
    check_seq("post_rst", 4, ea, ed, 9, 1'b0, 1'b0);

    // randomized traffic, including commands offered in the done cycle
    resp_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge PCLK);
      send_cmd(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
    end
    n = 0;
    @(negedge PCLK); #1;
    while (!cmd_ready && n < 400) begin
      @(negedge PCLK); #1;
      n++;
    end
    if (!cmd_ready) fail_now("final_idle");
    repeat (3) @(posedge PCLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
